// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, start/done
// handshake, results held from DONE until the next completed operation.
module seq_divider #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   cnt_r;
  logic [N-1:0]    rem_r;
  logic [N-1:0]    quo_r;
  logic [N-1:0]    divisor_r;
  logic            busy_r;
  logic            done_r;
  logic [N-1:0]    quotient_r;
  logic [N-1:0]    remainder_r;
  logic            dbz_r;

  logic            accept_s;
  logic [N:0]      shift_rem_s;
  logic [N:0]      trial_s;
  logic [N-1:0]    rem_nxt_s;
  logic [N-1:0]    quo_nxt_s;
  logic            quo_bit_s;

  // Trial subtraction for the current iteration and the start-acceptance window.
  // The partial remainder always stays below the divisor, so its extra top bit
  // is never set and only N bits are stored; the shifted value still needs N+1.
  always_comb begin
    accept_s    = 1'b0;
    shift_rem_s = {rem_r, quo_r[N-1]};
    trial_s     = shift_rem_s - {1'b0, divisor_r};
    rem_nxt_s   = shift_rem_s[N-1:0];
    quo_bit_s   = 1'b0;
    if ((state_r == IDLE) || (state_r == DONE)) begin
      accept_s = start;
    end else begin
      accept_s = 1'b0;
    end
    if (trial_s[N] == 1'b0) begin
      rem_nxt_s = trial_s[N-1:0];
      quo_bit_s = 1'b1;
    end else begin
      rem_nxt_s = shift_rem_s[N-1:0];
      quo_bit_s = 1'b0;
    end
    quo_nxt_s = {quo_r[N-2:0], quo_bit_s};
  end

  // Control FSM, iteration datapath and registered result outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      rem_r       <= {N{1'b0}};
      quo_r       <= {N{1'b0}};
      divisor_r   <= {N{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      quotient_r  <= {N{1'b0}};
      remainder_r <= {N{1'b0}};
      dbz_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (accept_s) begin
            divisor_r <= divisor;
            cnt_r     <= CW'(N);
            rem_r     <= {N{1'b0}};
            quo_r     <= dividend;
            if (divisor == {N{1'b0}}) begin
              // Zero divisor skips iteration and reports immediately.
              state_r     <= DONE;
              busy_r      <= 1'b0;
              done_r      <= 1'b1;
              quotient_r  <= {N{1'b1}};
              remainder_r <= dividend;
              dbz_r       <= 1'b1;
            end else begin
              state_r <= RUN;
              busy_r  <= 1'b1;
              done_r  <= 1'b0;
              dbz_r   <= 1'b0;
            end
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end
        end
        RUN: begin
          rem_r <= rem_nxt_s;
          quo_r <= quo_nxt_s;
          cnt_r <= cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            state_r     <= DONE;
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
            quotient_r  <= quo_nxt_s;
            remainder_r <= rem_nxt_s;
          end else begin
            state_r <= RUN;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: vector table for single operations plus
// hand-written sequences for ignored start, back-to-back accept and async reset.
module tb_seq_divider;

  localparam int N = 64;
  localparam logic [N-1:0] MAX = 64'hFFFF_FFFF_FFFF_FFFF;

  logic         clk;
  logic         reset;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  seq_divider #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend),
    .divisor(divisor), .busy(busy), .done(done), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dbz;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One operation: returns result, edges from accept to done, busy cycles and pulse width check.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        output logic [N-1:0] q, output logic [N-1:0] r, output logic dbz,
                        output int done_edge, output int busy_cnt, output logic one_wide);
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    done_edge = -1; busy_cnt = 0;
    q = '0; r = '0; dbz = 1'b0; one_wide = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (done) begin
        done_edge = k - 1;
        q = quotient; r = remainder; dbz = div_by_zero;
        break;
      end
      if (busy) busy_cnt++;
    end
    @(negedge clk);
    one_wide = !done && (quotient === q) && (remainder === r);
  endtask

  initial begin
    logic [N-1:0] q, r;
    logic dbz, one_wide, seen;
    int de, bc;

    vecs[0] = '{a: 64'd37,  b: 64'd22, q: 64'd1,  r: 64'd15, dbz: 1'b0};
    vecs[1] = '{a: 64'd13,  b: 64'd3,  q: 64'd4,  r: 64'd1,  dbz: 1'b0};
    vecs[2] = '{a: 64'd22,  b: 64'd37, q: 64'd0,  r: 64'd22, dbz: 1'b0};
    vecs[3] = '{a: 64'd0,   b: 64'd5,  q: 64'd0,  r: 64'd0,  dbz: 1'b0};
    vecs[4] = '{a: MAX,     b: 64'd1,  q: MAX,    r: 64'd0,  dbz: 1'b0};
    vecs[5] = '{a: MAX,     b: MAX,    q: 64'd1,  r: 64'd0,  dbz: 1'b0};
    vecs[6] = '{a: 64'd15,  b: 64'd0,  q: MAX,    r: 64'd15, dbz: 1'b1};
    vecs[7] = '{a: 64'd10,  b: 64'd3,  q: 64'd3,  r: 64'd1,  dbz: 1'b0};

    reset = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_quotient", quotient, 64'd0);
    check("reset_remainder", remainder, 64'd0);
    check("reset_dbz", {63'd0, div_by_zero}, 64'd0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, q, r, dbz, de, bc, one_wide);
      check($sformatf("vec%0d_quotient", i), q, vecs[i].q);
      check($sformatf("vec%0d_remainder", i), r, vecs[i].r);
      check($sformatf("vec%0d_dbz", i), {63'd0, dbz}, {63'd0, vecs[i].dbz});
      check($sformatf("vec%0d_done_edge", i), 64'(de), vecs[i].dbz ? 64'd0 : 64'd64);
      check($sformatf("vec%0d_busy_cycles", i), 64'(bc), vecs[i].dbz ? 64'd0 : 64'd64);
      check($sformatf("vec%0d_pulse_hold", i), {63'd0, one_wide}, 64'd1);
    end

    // 100/7 with an ignored start pulse mid-run, then start held through done.
    @(negedge clk);
    dividend = 64'd100; divisor = 64'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    de = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (done) begin de = k - 1; break; end
      if (k == 10) begin start = 1'b1; dividend = 64'd9; divisor = 64'd9; end
      if (k == 11) begin start = 1'b0; dividend = 64'd55; divisor = 64'd5; end
      if (k == 20) begin start = 1'b1; dividend = 64'd9; divisor = 64'd9; end
    end
    check("ign_done_edge", 64'(de), 64'd64);
    check("ign_quotient", quotient, 64'd14);
    check("ign_remainder", remainder, 64'd2);
    @(negedge clk);
    check("b2b_busy_rise", {63'd0, busy}, 64'd1);
    check("b2b_done_low", {63'd0, done}, 64'd0);
    start = 1'b0;
    de = -1;
    for (int k = 2; k <= 200; k++) begin
      @(negedge clk);
      if (done) begin de = k - 1; break; end
    end
    check("b2b_done_edge", 64'(de), 64'd64);
    check("b2b_quotient", quotient, 64'd1);
    check("b2b_remainder", remainder, 64'd0);

    // Asynchronous reset between clock edges in the middle of a run.
    @(negedge clk);
    dividend = 64'd200; divisor = 64'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_done", {63'd0, done}, 64'd0);
    check("arst_quotient", quotient, 64'd0);
    check("arst_remainder", remainder, 64'd0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check("arst_no_done", {63'd0, seen}, 64'd0);
    run_op(64'd37, 64'd22, q, r, dbz, de, bc, one_wide);
    check("post_rst_quotient", q, 64'd1);
    check("post_rst_remainder", r, 64'd15);
    check("post_rst_done_edge", 64'(de), 64'd64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
